// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the 2-way, 4-set write-back cache miss controller.
// Holds the FSM state type, the geometry constants and the bit layout of one
// way entry: {valid, lru, dirty, tag[2:0], data[2:0]}.
package cache_ctrl_pkg;

  localparam int unsigned TAG_W    = 3;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned DATA_W   = 3;
  localparam int unsigned NUM_SETS = 1 << IDX_W;

  // Way-entry layout.
  localparam int unsigned ENTRY_W   = 9;
  localparam int unsigned VALID_BIT = 8;
  localparam int unsigned LRU_BIT   = 7;
  localparam int unsigned DIRTY_BIT = 6;
  localparam int unsigned TAG_LSB   = 3;
  localparam int unsigned DATA_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWb,
    StFetch,
    StFill,
    StDone
  } state_e;

  // Packs one way entry in the layout above.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic              valid,
                                                    input logic              lru,
                                                    input logic              dirty,
                                                    input logic [TAG_W-1:0]  tag,
                                                    input logic [DATA_W-1:0] d);
    return {valid, lru, dirty, tag, d};
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/state/data array of the cache: NUM_SETS sets x 2 ways of packed entries.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high clear of every entry
//   rd_idx_i         - set to read; both ways come out combinationally
//   rd_way0_o/1_o    - entries of way 0 / way 1 of that set
//   wr_en_i          - write one way of one set at the next rising edge
//   wr_idx_i/way_i   - set and way being written
//   wr_entry_i       - new entry for that way
module cache_tag_store
  import cache_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [ENTRY_W-1:0] rd_way0_o,
  output logic [ENTRY_W-1:0] rd_way1_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic               wr_way_i,
  input  logic [ENTRY_W-1:0] wr_entry_i
);

  logic [NUM_SETS-1:0][1:0][ENTRY_W-1:0] mem_q, mem_d;

  // Every write marks the written way most recent, so the sibling way of the
  // same set loses its LRU bit in the same cycle.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_idx_i][wr_way_i]           = wr_entry_i;
      mem_d[wr_idx_i][~wr_way_i][LRU_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_way0_o = mem_q[rd_idx_i][0];
  assign rd_way1_o = mem_q[rd_idx_i][1];

endmodule

// File: rtl/cache_miss_controller.sv
// Miss-sequencing controller for the 2-way, 4-set write-back cache.
// Accepts one CPU request at a time, looks it up in the owned tag store and,
// on a miss, writes back a dirty victim, refills from memory and installs.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   req/wren/address/data - CPU request, sampled when req & ready
//   ready              - high in IDLE only
//   resp_valid         - one-cycle pulse in DONE with dadoParaCPU and hit
//   writeBack          - high in the write-back cycle
//   mem_addr/mem_wdata/mem_wren - main-memory port; mem_rdata one cycle after
module cache_miss_controller #(
  parameter int unsigned TAG_W  = cache_ctrl_pkg::TAG_W,
  parameter int unsigned IDX_W  = cache_ctrl_pkg::IDX_W,
  parameter int unsigned DATA_W = cache_ctrl_pkg::DATA_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   wren,
  input  logic [TAG_W+IDX_W-1:0] address,
  input  logic [DATA_W-1:0]      data,
  output logic                   ready,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      dadoParaCPU,
  output logic                   hit,
  output logic                   writeBack,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [DATA_W-1:0]      mem_rdata
);
  import cache_ctrl_pkg::*;

  localparam int unsigned AW = TAG_W + IDX_W;

  state_e            state_q, state_d;
  logic              wren_q, wren_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              victim_q, victim_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [ENTRY_W-1:0] e0, e1, hit_entry, victim_entry, wr_entry;
  logic               way0_hit, way1_hit, hit_any, hit_way, victim, victim_dirty, wr_en, wr_way;

  assign tag = addr_q[AW-1:IDX_W];
  assign idx = addr_q[IDX_W-1:0];

  cache_tag_store u_store (
    .clk_i     (clock),
    .rst_i     (reset),
    .rd_idx_i  (idx),
    .rd_way0_o (e0),
    .rd_way1_o (e1),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx),
    .wr_way_i  (wr_way),
    .wr_entry_i(wr_entry)
  );

  // Lookup and victim choice on the latched request.
  always_comb begin
    way0_hit = e0[VALID_BIT] && (e0[TAG_LSB +: TAG_W] == tag);
    way1_hit = e1[VALID_BIT] && (e1[TAG_LSB +: TAG_W] == tag);
    hit_any  = way0_hit || way1_hit;
    hit_way  = !way0_hit;  // way 0 wins a double match
    hit_entry = hit_way ? e1 : e0;
    if (!e0[VALID_BIT])      victim = 1'b0;
    else if (!e1[VALID_BIT]) victim = 1'b1;
    else                     victim = e0[LRU_BIT];  // way with LRU=0
    victim_entry = victim ? e1 : e0;
    victim_dirty = victim_entry[VALID_BIT] && victim_entry[DIRTY_BIT];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req) state_d = StLookup;
      StLookup: state_d = hit_any ? StDone : (victim_dirty ? StWb : StFetch);
      StWb:     state_d = StFetch;
      StFetch:  state_d = StFill;
      StFill:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next values and array writes. mem_addr/mem_wdata are loaded on
  // entry to WB/FETCH so they are registered yet valid in those cycles.
  always_comb begin
    wren_d      = wren_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    hit_d       = hit_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    wr_way      = 1'b0;
    wr_entry    = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          wren_d  = wren;
          addr_d  = address;
          wdata_d = data;
        end
      end
      StLookup: begin
        hit_d = hit_any;
        if (hit_any) begin
          wr_en    = 1'b1;
          wr_way   = hit_way;
          wr_entry = make_entry(1'b1, 1'b1, wren_q | hit_entry[DIRTY_BIT], tag,
                                wren_q ? wdata_q : hit_entry[DATA_LSB +: DATA_W]);
          rdata_d  = wren_q ? wdata_q : hit_entry[DATA_LSB +: DATA_W];
        end else begin
          victim_d = victim;
          if (victim_dirty) begin
            mem_addr_d  = {victim_entry[TAG_LSB +: TAG_W], idx};
            mem_wdata_d = victim_entry[DATA_LSB +: DATA_W];
          end else begin
            mem_addr_d = addr_q;
          end
        end
      end
      StWb: mem_addr_d = addr_q;
      StFill: begin
        wr_en    = 1'b1;
        wr_way   = victim_q;
        wr_entry = make_entry(1'b1, 1'b1, wren_q, tag, wren_q ? wdata_q : mem_rdata);
        rdata_d  = wren_q ? wdata_q : mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      victim_q    <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      victim_q    <= victim_d;
      hit_q       <= hit_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs: decoded from state or straight from registers.
  always_comb begin
    ready       = (state_q == StIdle);
    resp_valid  = (state_q == StDone);
    writeBack   = (state_q == StWb);
    mem_wren    = (state_q == StWb);
    hit         = hit_q;
    dadoParaCPU = rdata_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
  end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller: miss/hit latency, write-back,
// LRU victim choice, write-allocate, reset mid-operation and request gating.
module tb_cache_miss_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0, wren = 1'b0;
  logic [4:0] address = '0;
  logic [2:0] data = '0, mem_rdata = '0;
  logic       ready, resp_valid, hit, writeBack, mem_wren;
  logic [2:0] dadoParaCPU, mem_wdata;
  logic [4:0] mem_addr;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-access observations filled in by do_access.
  int         lat, wb_cyc, wr_cyc;
  logic       obs_hit;
  logic [2:0] obs_dout, wb_data;
  logic [4:0] wb_addr, done_addr;

  cache_miss_controller dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .wren       (wren),
    .address    (address),
    .data       (data),
    .ready      (ready),
    .resp_valid (resp_valid),
    .dadoParaCPU(dadoParaCPU),
    .hit        (hit),
    .writeBack  (writeBack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Issues one request and records what the DUT did until resp_valid.
  // lat counts cycles after the accept cycle; -1 means no response in time.
  task automatic do_access(input logic w, input logic [4:0] a, input logic [2:0] d);
    int guard;
    lat = -1; wb_cyc = 0; wr_cyc = 0; obs_hit = 1'bx; obs_dout = 'x;
    wb_addr = 'x; wb_data = 'x; done_addr = 'x;
    @(negedge clock);
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clock); guard++; end
    req = 1'b1; wren = w; address = a; data = d;
    @(negedge clock);
    req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (writeBack) begin wb_cyc++; wb_addr = mem_addr; wb_data = mem_wdata; end
      if (mem_wren) wr_cyc++;
      if (resp_valid) begin
        lat = c; obs_hit = hit; obs_dout = dadoParaCPU; done_addr = mem_addr;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", hit); end
    n_cmp++; if (writeBack !== 1'b0) begin n_fail++; $display("FAIL rst_writeBack: got %b want 0", writeBack); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wren: got %b want 0", mem_wren); end
    n_cmp++; if (dadoParaCPU !== 3'b000) begin n_fail++; $display("FAIL rst_dado: got %b want 000", dadoParaCPU); end
    n_cmp++; if (mem_addr !== 5'b00000) begin n_fail++; $display("FAIL rst_mem_addr: got %b want 00000", mem_addr); end
    n_cmp++; if (mem_wdata !== 3'b000) begin n_fail++; $display("FAIL rst_mem_wdata: got %b want 000", mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_read_miss_hit;
    mem_rdata = 3'b110;
    do_access(1'b0, 5'b10101, 3'b000);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL miss_lat: got %0d want 4", lat); end
    n_cmp++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b want 0", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b110) begin n_fail++; $display("FAIL miss_data: got %b want 110", obs_dout); end
    n_cmp++; if (done_addr !== 5'b10101) begin n_fail++; $display("FAIL miss_fetch_addr: got %b want 10101", done_addr); end
    n_cmp++; if (wb_cyc !== 0) begin n_fail++; $display("FAIL miss_no_wb: got %0d want 0", wb_cyc); end
    mem_rdata = 3'b000;
    do_access(1'b0, 5'b10101, 3'b000);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL hit_lat: got %0d want 2", lat); end
    n_cmp++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL hit_hit: got %b want 1", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b110) begin n_fail++; $display("FAIL hit_data: got %b want 110", obs_dout); end
    n_cmp++; if (wr_cyc !== 0) begin n_fail++; $display("FAIL hit_no_memwr: got %0d want 0", wr_cyc); end
  endtask

  task automatic test_write_hit;
    do_access(1'b1, 5'b10101, 3'b011);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL whit_lat: got %0d want 2", lat); end
    n_cmp++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL whit_hit: got %b want 1", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b011) begin n_fail++; $display("FAIL whit_data: got %b want 011", obs_dout); end
    do_access(1'b0, 5'b10101, 3'b000);
    n_cmp++; if (obs_dout !== 3'b011) begin n_fail++; $display("FAIL whit_readback: got %b want 011", obs_dout); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL whit_readback_lat: got %0d want 2", lat); end
  endtask

  task automatic test_lru_victim;
    mem_rdata = 3'b001;
    do_access(1'b0, 5'b01101, 3'b000);  // fills way 1
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL fill_way1_lat: got %0d want 4", lat); end
    n_cmp++; if (obs_dout !== 3'b001) begin n_fail++; $display("FAIL fill_way1_data: got %b want 001", obs_dout); end
    do_access(1'b0, 5'b10101, 3'b000);  // way 0 becomes most recent
    n_cmp++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL lru_touch_hit: got %b want 1", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b011) begin n_fail++; $display("FAIL lru_touch_data: got %b want 011", obs_dout); end
    mem_rdata = 3'b100;
    do_access(1'b0, 5'b11101, 3'b000);  // evicts clean way 1
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL clean_evict_lat: got %0d want 4", lat); end
    n_cmp++; if (wb_cyc !== 0) begin n_fail++; $display("FAIL clean_evict_no_wb: got %0d want 0", wb_cyc); end
    n_cmp++; if (obs_dout !== 3'b100) begin n_fail++; $display("FAIL clean_evict_data: got %b want 100", obs_dout); end
  endtask

  task automatic test_dirty_writeback;
    mem_rdata = 3'b010;
    do_access(1'b0, 5'b00001, 3'b000);  // evicts dirty way 0 (tag 101, data 011)
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL wb_lat: got %0d want 5", lat); end
    n_cmp++; if (wb_cyc !== 1) begin n_fail++; $display("FAIL wb_cycles: got %0d want 1", wb_cyc); end
    n_cmp++; if (wr_cyc !== 1) begin n_fail++; $display("FAIL wb_memwr_cycles: got %0d want 1", wr_cyc); end
    n_cmp++; if (wb_addr !== 5'b10101) begin n_fail++; $display("FAIL wb_addr: got %b want 10101", wb_addr); end
    n_cmp++; if (wb_data !== 3'b011) begin n_fail++; $display("FAIL wb_data: got %b want 011", wb_data); end
    n_cmp++; if (obs_dout !== 3'b010) begin n_fail++; $display("FAIL wb_fill_data: got %b want 010", obs_dout); end
    n_cmp++; if (done_addr !== 5'b00001) begin n_fail++; $display("FAIL wb_fetch_addr: got %b want 00001", done_addr); end
    // Refilled line is clean: evicting it later needs no write-back.
    mem_rdata = 3'b111;
    do_access(1'b0, 5'b01001, 3'b000);  // evicts way 1
    do_access(1'b0, 5'b10001, 3'b000);  // evicts way 0 (refilled, clean)
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL refill_clean_lat: got %0d want 4", lat); end
    n_cmp++; if (wb_cyc !== 0) begin n_fail++; $display("FAIL refill_clean_no_wb: got %0d want 0", wb_cyc); end
  endtask

  task automatic test_write_allocate;
    mem_rdata = 3'b111;
    do_access(1'b1, 5'b00110, 3'b101);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL walloc_lat: got %0d want 4", lat); end
    n_cmp++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL walloc_hit: got %b want 0", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b101) begin n_fail++; $display("FAIL walloc_data: got %b want 101", obs_dout); end
    do_access(1'b0, 5'b00110, 3'b000);
    n_cmp++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL walloc_reread_hit: got %b want 1", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b101) begin n_fail++; $display("FAIL walloc_reread_data: got %b want 101", obs_dout); end
  endtask

  task automatic test_reset_during_wb;
    int guard;
    mem_rdata = 3'b000;
    do_access(1'b1, 5'b00011, 3'b111);  // way 0 dirty
    do_access(1'b1, 5'b01011, 3'b010);  // way 1 dirty, way 0 now LRU
    @(negedge clock);
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clock); guard++; end
    req = 1'b1; wren = 1'b0; address = 5'b10011;
    @(negedge clock);  // LOOKUP
    req = 1'b0;
    @(negedge clock);  // WB
    n_cmp++; if (writeBack !== 1'b1) begin n_fail++; $display("FAIL rwb_writeBack: got %b want 1", writeBack); end
    n_cmp++; if (mem_addr !== 5'b00011) begin n_fail++; $display("FAIL rwb_addr: got %b want 00011", mem_addr); end
    n_cmp++; if (mem_wdata !== 3'b111) begin n_fail++; $display("FAIL rwb_wdata: got %b want 111", mem_wdata); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rwb_ready: got %b want 1", ready); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL rwb_mem_wren: got %b want 0", mem_wren); end
    n_cmp++; if (writeBack !== 1'b0) begin n_fail++; $display("FAIL rwb_wb_clear: got %b want 0", writeBack); end
    n_cmp++; if (mem_addr !== 5'b00000) begin n_fail++; $display("FAIL rwb_mem_addr: got %b want 00000", mem_addr); end
    mem_rdata = 3'b110;
    do_access(1'b0, 5'b10101, 3'b000);
    n_cmp++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL rwb_cleared_hit: got %b want 0", obs_hit); end
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rwb_cleared_lat: got %0d want 4", lat); end
    n_cmp++; if (wr_cyc !== 0) begin n_fail++; $display("FAIL rwb_no_memwr: got %0d want 0", wr_cyc); end
  endtask

  task automatic test_req_ignored;
    int guard;
    // A write request pulsed through LOOKUP and DONE must be dropped.
    @(negedge clock);
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clock); guard++; end
    req = 1'b1; wren = 1'b0; address = 5'b10101; data = 3'b000;
    @(negedge clock);  // LOOKUP
    wren = 1'b1; address = 5'b00000; data = 3'b111;
    @(negedge clock);  // DONE
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL ign_resp: got %b want 1", resp_valid); end
    n_cmp++; if (dadoParaCPU !== 3'b110) begin n_fail++; $display("FAIL ign_data: got %b want 110", dadoParaCPU); end
    @(negedge clock);  // IDLE
    req = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ign_idle: got %b want 1", ready); end
    @(negedge clock);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ign_not_taken: got %b want 1", ready); end
    mem_rdata = 3'b101;
    do_access(1'b0, 5'b00000, 3'b000);
    n_cmp++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL ign_no_write_hit: got %b want 0", obs_hit); end
    n_cmp++; if (obs_dout !== 3'b101) begin n_fail++; $display("FAIL ign_no_write_data: got %b want 101", obs_dout); end
  endtask

  task automatic test_back_to_back;
    int guard;
    // req held high: second accept only in the IDLE cycle after DONE.
    @(negedge clock);
    guard = 0;
    while (!ready && guard < 20) begin @(negedge clock); guard++; end
    req = 1'b1; wren = 1'b0; address = 5'b10101;
    @(negedge clock);  // T+1
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", ready); end
    @(negedge clock);  // T+2 DONE
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_resp1: got %b want 1", resp_valid); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy: got %b want 0", ready); end
    @(negedge clock);  // T+3 IDLE, re-accept
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", ready); end
    @(negedge clock);  // T+4 LOOKUP
    req = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept: got %b want 0", ready); end
    @(negedge clock);  // T+5 DONE
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_resp2: got %b want 1", resp_valid); end
    n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL b2b_hit2: got %b want 1", hit); end
    repeat (2) @(negedge clock);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_quiet: got %b want 1", ready); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_lru_victim();
    test_dirty_writeback();
    test_write_allocate();
    test_reset_during_wb();
    test_req_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
